// File: rtl/smartlift_sched.sv
// SCAN-policy lift scheduler for the DE2: latches floor calls into a pending mask,
// models per-floor travel time and a timed door dwell, and drives the HEX/LED indicators.
module smartlift_sched #(
  parameter int  N_FLOORS        = 9,
  parameter int  TICKS_PER_FLOOR = 50000000,
  parameter int  DOOR_TICKS      = 100000000,
  localparam int FLOOR_W         = $clog2(N_FLOORS)
) (
  input  logic                CLOCK_50,
  input  logic                KEY1,
  input  logic                KEY0,
  input  logic [N_FLOORS-1:0] SW,
  output logic [6:0]          HEX0,
  output logic [6:0]          HEX1,
  output logic                LED_G,
  output logic                LED_R,
  output logic [FLOOR_W-1:0]  CUR_FLOOR,
  output logic [1:0]          DIR,
  output logic [N_FLOORS-1:0] PEND
);

  localparam int T_MAX   = (TICKS_PER_FLOOR > DOOR_TICKS) ? TICKS_PER_FLOOR : DOOR_TICKS;
  localparam int TIMER_W = $clog2(T_MAX + 1);

  localparam logic [TIMER_W-1:0] MOVE_LAST = TIMER_W'(TICKS_PER_FLOOR - 1);
  localparam logic [TIMER_W-1:0] DOOR_LAST = TIMER_W'(DOOR_TICKS - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] FLOOR_ONE = FLOOR_W'(1);
  localparam logic [6:0]         SEG_BLANK = 7'b1111111;
  localparam logic [6:0]         SEG_UNDER = 7'b1110111;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  state_t               state_q, state_d;
  logic                 key_s1_q, key_s1_d;
  logic                 key_s2_q, key_s2_d;
  logic                 key_s3_q, key_s3_d;
  logic [FLOOR_W-1:0]   cur_floor_q, cur_floor_d;
  logic                 up_q, up_d;
  logic [N_FLOORS-1:0]  pend_q, pend_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [6:0]           hex0_q, hex0_d;

  logic                 press;
  logic                 call_ok;
  logic [FLOOR_W-1:0]   call_idx;
  logic                 ahead_up;
  logic                 ahead_dn;
  logic [N_FLOORS-1:0]  capture;
  logic [N_FLOORS-1:0]  serve;
  logic [FLOOR_W-1:0]   next_floor;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [FLOOR_W-1:0] onehot_index(input logic [N_FLOORS-1:0] v);
    onehot_index = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (v[i]) onehot_index = FLOOR_W'(i);
    end
  endfunction

  // KEY0 is asynchronous: two flops to resolve metastability, a third to spot the falling edge
  always_comb begin
    key_s1_d = KEY0;
    key_s2_d = key_s1_q;
    key_s3_d = key_s2_q;
    press    = key_s3_q & ~key_s2_q;
    call_ok  = press & $onehot(SW);
    call_idx = onehot_index(SW);
  end

  always_comb begin
    ahead_up = 1'b0;
    ahead_dn = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pend_q[i] && (i > int'(cur_floor_q))) ahead_up = 1'b1;
      if (pend_q[i] && (i < int'(cur_floor_q))) ahead_dn = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    up_d        = up_q;
    timer_d     = timer_q;
    hex0_d      = hex0_q;
    serve       = '0;
    capture     = call_ok ? SW : '0;
    next_floor  = cur_floor_q;

    if (press) hex0_d = call_ok ? seg7(4'(call_idx)) : SEG_UNDER;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (pend_q[cur_floor_q]) begin
          state_d            = S_DOOR;
          serve[cur_floor_q] = 1'b1;
        end else if (|pend_q) begin
          state_d = S_MOVE;
          // keep heading while calls lie ahead, otherwise turn toward the remaining ones
          up_d    = up_q ? ahead_up : !ahead_dn;
        end
      end
      S_MOVE: begin
        if (timer_q == MOVE_LAST) begin
          timer_d = '0;
          if (up_q) next_floor = (cur_floor_q == TOP_FLOOR) ? cur_floor_q : cur_floor_q + FLOOR_ONE;
          else      next_floor = (cur_floor_q == '0) ? cur_floor_q : cur_floor_q - FLOOR_ONE;
          cur_floor_d = next_floor;
          if (pend_q[next_floor] || (next_floor == '0) || (next_floor == TOP_FLOOR)) begin
            state_d           = S_DOOR;
            serve[next_floor] = 1'b1;
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      S_DOOR: begin
        if (call_ok && (call_idx == cur_floor_q)) begin
          timer_d = '0;
          capture = '0;
        end else if (timer_q == DOOR_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    // a service in the same cycle as a capture of that floor leaves the bit clear
    pend_d = (pend_q | capture) & ~serve;
  end

  always_ff @(posedge CLOCK_50 or negedge KEY1) begin
    if (!KEY1) begin
      key_s1_q    <= 1'b1;
      key_s2_q    <= 1'b1;
      key_s3_q    <= 1'b1;
      state_q     <= S_IDLE;
      cur_floor_q <= '0;
      up_q        <= 1'b1;
      pend_q      <= '0;
      timer_q     <= '0;
      hex0_q      <= SEG_BLANK;
    end else begin
      key_s1_q    <= key_s1_d;
      key_s2_q    <= key_s2_d;
      key_s3_q    <= key_s3_d;
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      up_q        <= up_d;
      pend_q      <= pend_d;
      timer_q     <= timer_d;
      hex0_q      <= hex0_d;
    end
  end

  always_comb begin
    LED_G     = (state_q == S_DOOR);
    LED_R     = (state_q != S_DOOR);
    DIR       = (state_q == S_MOVE) ? (up_q ? 2'd1 : 2'd2) : 2'd0;
    HEX0      = hex0_q;
    HEX1      = seg7(4'(cur_floor_q));
    CUR_FLOOR = cur_floor_q;
    PEND      = pend_q;
  end

endmodule

// File: tb/tb_smartlift_sched.sv
// Bench for smartlift_sched: directed scenarios plus a randomized run checked
// against a behavioural lift model kept in the bench.
module tb_smartlift_sched;
  localparam int NF  = 9;
  localparam int TPF = 4;
  localparam int DT  = 3;
  localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2;
  localparam logic [6:0] SEG [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000, 7'b0010000};
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] UNDER = 7'b1110111;

  logic          clk = 1'b0;
  logic          key1, key0;
  logic [NF-1:0] sw;
  logic [6:0]    hex0, hex1;
  logic          led_g, led_r;
  logic [3:0]    cur_floor;
  logic [1:0]    dir;
  logic [NF-1:0] pend;

  int vectors = 0;
  int errors  = 0;
  int doors[$];
  int legs[$];

  // behavioural model state
  int            m_floor, m_mode, m_cnt;
  bit            m_up;
  bit [NF-1:0]   m_pend;
  logic [6:0]    m_hex0;
  bit            m_hist [0:3];

  smartlift_sched #(.N_FLOORS(NF), .TICKS_PER_FLOOR(TPF), .DOOR_TICKS(DT)) dut (
    .CLOCK_50(clk), .KEY1(key1), .KEY0(key0), .SW(sw),
    .HEX0(hex0), .HEX1(hex1), .LED_G(led_g), .LED_R(led_r),
    .CUR_FLOOR(cur_floor), .DIR(dir), .PEND(pend)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset();
    m_floor = 0; m_mode = M_IDLE; m_cnt = 0; m_up = 1'b1; m_pend = '0; m_hex0 = BLANK;
    for (int i = 0; i < 4; i++) m_hist[i] = 1'b1;
  endtask

  function automatic logic [1:0] m_dir();
    if (m_mode != M_MOVE) return 2'd0;
    return m_up ? 2'd1 : 2'd2;
  endfunction

  // One clock of the lift as the rules describe it: a press lands when the key was
  // seen high then low two and three samples back.
  task automatic model_step();
    bit press, ok, above, below;
    int idx, svc;
    bit [NF-1:0] cap;
    if (!key1) begin model_reset(); return; end
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = key0;
    press = m_hist[3] && !m_hist[2];
    ok = press && ($countones(sw) == 1);
    idx = 0;
    for (int i = 0; i < NF; i++) if (sw[i]) idx = i;
    if (press) m_hex0 = ok ? SEG[idx] : UNDER;
    cap = ok ? sw : '0;
    svc = -1;
    above = 0; below = 0;
    for (int i = 0; i < NF; i++) begin
      if (m_pend[i] && i > m_floor) above = 1;
      if (m_pend[i] && i < m_floor) below = 1;
    end
    case (m_mode)
      M_IDLE: begin
        if (m_pend[m_floor]) begin m_mode = M_DOOR; m_cnt = 0; svc = m_floor; end
        else if (m_pend != 0) begin
          if (m_up && !above) m_up = 0;
          else if (!m_up && !below) m_up = 1;
          m_mode = M_MOVE; m_cnt = 0;
        end
      end
      M_MOVE: begin
        m_cnt++;
        if (m_cnt == TPF) begin
          m_cnt = 0;
          m_floor = m_up ? m_floor + 1 : m_floor - 1;
          if (m_floor > NF-1) m_floor = NF-1;
          if (m_floor < 0) m_floor = 0;
          if (m_pend[m_floor] || m_floor == 0 || m_floor == NF-1) begin
            m_mode = M_DOOR; svc = m_floor;
          end
        end
      end
      default: begin
        if (ok && idx == m_floor) begin m_cnt = 0; cap = '0; end
        else begin
          m_cnt++;
          if (m_cnt == DT) begin m_mode = M_IDLE; m_cnt = 0; end
        end
      end
    endcase
    m_pend |= cap;
    if (svc >= 0) m_pend[svc] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    key1 = 1'b0; #1; model_reset();
    tick();
    key1 = 1'b1;
  endtask

  task automatic press_floor(input logic [NF-1:0] s);
    sw = s; key0 = 1'b0;
    tick(); tick(); tick();
    key0 = 1'b1;
  endtask

  function automatic string q2s(input int q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  task automatic run_until_idle(input int budget, output bit timed_out);
    logic prev_g; logic [1:0] prev_dir; int n;
    doors.delete(); legs.delete();
    prev_g = 1'b0; prev_dir = 2'd0; n = 0; timed_out = 0;
    forever begin
      if (led_g && !prev_g) doors.push_back(int'(cur_floor));
      if (dir != 2'd0 && prev_dir == 2'd0) legs.push_back(int'(dir));
      prev_g = led_g; prev_dir = dir;
      if (pend == '0 && !led_g && dir == 2'd0) break;
      if (n >= budget) begin timed_out = 1; break; end
      tick(); n++;
    end
  endtask

  task automatic test_reset();
    key1 = 1'b0; key0 = 1'b1; sw = '0; #2; model_reset();
    tick(); tick();
    vectors++; if (cur_floor !== 4'd0) begin errors++; $display("FAIL reset_floor: got %0d expected 0", cur_floor); end
    vectors++; if (dir !== 2'd0) begin errors++; $display("FAIL reset_dir: got %0d expected 0", dir); end
    vectors++; if (pend !== '0) begin errors++; $display("FAIL reset_pend: got %h expected 000", pend); end
    vectors++; if ({led_g, led_r} !== 2'b01) begin errors++; $display("FAIL reset_leds: got g=%b r=%b expected g=0 r=1", led_g, led_r); end
    vectors++; if (hex0 !== BLANK) begin errors++; $display("FAIL reset_hex0: got %b expected %b", hex0, BLANK); end
    vectors++; if (hex1 !== SEG[0]) begin errors++; $display("FAIL reset_hex1: got %b expected %b", hex1, SEG[0]); end
    key1 = 1'b1;
    tick();
    vectors++; if (pend !== '0 || dir !== 2'd0 || led_g !== 1'b0) begin errors++; $display("FAIL reset_release: got pend=%h dir=%0d g=%b expected 000/0/0", pend, dir, led_g); end
  endtask

  task automatic test_single_call();
    int n, g;
    sw = 9'h008; key0 = 1'b0;
    tick(); tick();
    vectors++; if (pend !== 9'h000) begin errors++; $display("FAIL call3_early: got %h expected 000", pend); end
    tick();
    vectors++; if (pend !== 9'h008) begin errors++; $display("FAIL call3_pend: got %h expected 008", pend); end
    vectors++; if (hex0 !== 7'b0110000) begin errors++; $display("FAIL call3_hex0: got %b expected 0110000", hex0); end
    key0 = 1'b1;
    n = 0;
    while (dir !== 2'd1 && n < 10) begin tick(); n++; end
    vectors++; if (dir !== 2'd1) begin errors++; $display("FAIL call3_move_entry: got dir=%0d after %0d cycles expected 1", dir, n); end
    n = 0;
    while (cur_floor !== 4'd3 && n < 40) begin tick(); n++; end
    vectors++; if (n != 12) begin errors++; $display("FAIL call3_travel: got %0d cycles expected 12", n); end
    g = 0;
    while (led_g === 1'b1 && g < 20) begin
      vectors++; if (led_r !== 1'b0) begin errors++; $display("FAIL call3_led_r: got %b expected 0", led_r); end
      tick(); g++;
    end
    vectors++; if (g != DT) begin errors++; $display("FAIL call3_door: got %0d cycles expected %0d", g, DT); end
    vectors++; if (pend !== '0 || hex1 !== 7'b0110000) begin errors++; $display("FAIL call3_after: got pend=%h hex1=%b expected 000/0110000", pend, hex1); end
  endtask

  task automatic test_scan_up();
    bit to;
    do_reset();
    press_floor(9'h020);
    tick(); tick();
    press_floor(9'h004);
    vectors++; if (pend !== 9'h024 || cur_floor >= 4'd2) begin errors++; $display("FAIL scan_pend: got pend=%h floor=%0d expected 024 below floor 2", pend, cur_floor); end
    run_until_idle(120, to);
    vectors++; if (to) begin errors++; $display("FAIL scan_timeout: got timeout expected idle within 120"); end
    vectors++; if (doors.size() != 2 || doors[0] != 2 || doors[1] != 5) begin errors++; $display("FAIL scan_doors: got %s expected 2 5", q2s(doors)); end
    vectors++; if (legs.size() != 2 || legs[0] != 1 || legs[1] != 1) begin errors++; $display("FAIL scan_dir: got %s expected 1 1", q2s(legs)); end
  endtask

  task automatic test_reverse();
    bit to; int n;
    do_reset();
    press_floor(9'h010);
    n = 0;
    while (cur_floor !== 4'd2 && n < 40) begin tick(); n++; end
    vectors++; if (cur_floor !== 4'd2) begin errors++; $display("FAIL rev_reach2: got floor %0d expected 2", cur_floor); end
    press_floor(9'h040);
    tick(); tick();
    press_floor(9'h002);
    tick();
    vectors++; if (pend !== 9'h042 || cur_floor !== 4'd4) begin errors++; $display("FAIL rev_pend: got pend=%h floor=%0d expected 042 at 4", pend, cur_floor); end
    run_until_idle(150, to);
    vectors++; if (to) begin errors++; $display("FAIL rev_timeout: got timeout expected idle within 150"); end
    vectors++; if (doors.size() != 3 || doors[0] != 4 || doors[1] != 6 || doors[2] != 1) begin errors++; $display("FAIL rev_doors: got %s expected 4 6 1", q2s(doors)); end
    vectors++; if (legs.size() != 2 || legs[0] != 1 || legs[1] != 2) begin errors++; $display("FAIL rev_dir: got %s expected 1 2", q2s(legs)); end
  endtask

  task automatic test_bad_sw();
    press_floor(9'b000000011);
    tick(); tick();
    vectors++; if (pend !== '0 || hex0 !== UNDER) begin errors++; $display("FAIL bad_two_hot: got pend=%h hex0=%b expected 000/%b", pend, hex0, UNDER); end
    vectors++; if (dir !== 2'd0 || led_g !== 1'b0) begin errors++; $display("FAIL bad_two_hot_idle: got dir=%0d g=%b expected 0/0", dir, led_g); end
    press_floor(9'h002);
    repeat (6) tick();
    vectors++; if (hex0 !== SEG[1] || pend !== '0) begin errors++; $display("FAIL bad_refresh: got hex0=%b pend=%h expected %b/000", hex0, pend, SEG[1]); end
    press_floor(9'h000);
    tick(); tick();
    vectors++; if (pend !== '0 || hex0 !== UNDER || cur_floor !== 4'd1) begin errors++; $display("FAIL bad_zero: got pend=%h hex0=%b floor=%0d expected 000/%b/1", pend, hex0, cur_floor, UNDER); end
  endtask

  task automatic test_door_restart();
    int g;
    press_floor(9'h004);
    tick(); tick(); tick();
    key0 = 1'b0;
    g = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (led_g) begin
        g++;
        vectors++; if (pend[2] !== 1'b0 || cur_floor !== 4'd2) begin errors++; $display("FAIL restart_pend: got pend=%h floor=%0d expected bit2 clear at 2", pend, cur_floor); end
      end
    end
    key0 = 1'b1;
    vectors++; if (g != DT + 1) begin errors++; $display("FAIL restart_door: got %0d open cycles expected %0d", g, DT + 1); end
    vectors++; if (pend !== '0 || hex0 !== SEG[2]) begin errors++; $display("FAIL restart_after: got pend=%h hex0=%b expected 000/%b", pend, hex0, SEG[2]); end
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_move();
    press_floor(9'h020);
    tick(); tick(); tick();
    vectors++; if (cur_floor !== 4'd2 || dir !== 2'd1) begin errors++; $display("FAIL midmove_setup: got floor=%0d dir=%0d expected 2/1", cur_floor, dir); end
    key1 = 1'b0; #1; model_reset();
    vectors++; if (cur_floor !== 4'd0 || pend !== '0 || led_r !== 1'b1 || hex0 !== BLANK || dir !== 2'd0) begin
      errors++; $display("FAIL midmove_reset: got floor=%0d pend=%h r=%b hex0=%b dir=%0d expected 0/000/1/%b/0", cur_floor, pend, led_r, hex0, dir, BLANK);
    end
    tick(); tick();
    key1 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      vectors++; if (cur_floor !== 4'd0 || dir !== 2'd0 || pend !== '0) begin errors++; $display("FAIL midmove_still: got floor=%0d dir=%0d pend=%h expected 0/0/000", cur_floor, dir, pend); end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 3;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (hold == 0) begin
        if (key0) begin
          key0 = 1'b0;
          hold = $urandom_range(4, 1);
          if ($urandom_range(9, 0) < 8) sw = NF'(1) << $urandom_range(NF-1, 0);
          else sw = NF'($urandom);
        end else begin
          key0 = 1'b1;
          hold = $urandom_range(12, 3);
        end
      end
      hold--;
      tick();
      vectors++; if (pend !== m_pend) begin errors++; $display("FAIL rnd_pend c%0d: got %h expected %h", c, pend, m_pend); end
      vectors++; if (cur_floor !== 4'(m_floor)) begin errors++; $display("FAIL rnd_floor c%0d: got %0d expected %0d", c, cur_floor, m_floor); end
      vectors++; if (dir !== m_dir()) begin errors++; $display("FAIL rnd_dir c%0d: got %0d expected %0d", c, dir, m_dir()); end
      vectors++; if (led_g !== (m_mode == M_DOOR) || led_r !== (m_mode != M_DOOR)) begin errors++; $display("FAIL rnd_leds c%0d: got g=%b r=%b expected door=%0d", c, led_g, led_r, m_mode == M_DOOR); end
      vectors++; if (hex0 !== m_hex0 || hex1 !== SEG[m_floor]) begin errors++; $display("FAIL rnd_hex c%0d: got %b/%b expected %b/%b", c, hex0, hex1, m_hex0, SEG[m_floor]); end
    end
    key0 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_scan_up();
    test_reverse();
    test_bad_sw();
    test_door_restart();
    test_reset_mid_move();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
